// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: core-side fetch request/response plus the instruction-memory handshake.
// The slave modport is the fetch unit's view; master is the core + memory side.
interface fetch_unit_if;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  pc, pc_valid, mem_ack, mem_rdata,
        output instruction, instr_valid, busy, fault, fault_cause, mem_addr, mem_req
    );

    modport master (
        output pc, pc_valid, mem_ack, mem_rdata,
        input  instruction, instr_valid, busy, fault, fault_cause, mem_addr, mem_req
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: accepts a PC, runs a req/ack handshake with instruction memory
// and returns the fetched word. Misaligned and timed-out fetches return a NOP with a fault.
// Optional feature macro: FETCH_TIMEOUT_EN builds the WAIT timeout counter and cause 2'b10.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.slave  bus
);

    localparam logic [31:0] Nop         = 32'h0000_0013;
    localparam logic [1:0]  CauseNone   = 2'b00;
    localparam logic [1:0]  CauseMisal  = 2'b01;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0]  CauseTmo    = 2'b10;
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
`endif

    // Reject out-of-range timeout settings at elaboration.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        busy_q;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [31:0] mem_addr_q;
    logic        mem_req_q;
`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  tmo_cnt_q;
`endif

    // Fetch FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            instr_q       <= Nop;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            cause_q       <= CauseNone;
            mem_addr_q    <= RESET_PC;
            mem_req_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= 8'd0;
`endif
        end else begin
            // Response strobes are single-cycle pulses.
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.pc_valid) begin
                        if (bus.pc[1:0] == 2'b00) begin
                            mem_addr_q <= bus.pc;
                            mem_req_q  <= 1'b1;
                            busy_q     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                            tmo_cnt_q  <= 8'd0;
`endif
                            state_q    <= StWait;
                        end else begin
                            // Misaligned: fault without touching memory.
                            instr_q       <= Nop;
                            instr_valid_q <= 1'b1;
                            fault_q       <= 1'b1;
                            cause_q       <= CauseMisal;
                        end
                    end
                end
                StWait: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (bus.mem_ack) begin
                        instr_q       <= bus.mem_rdata;
                        instr_valid_q <= 1'b1;
                        cause_q       <= CauseNone;
                        mem_req_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt_q == TimeoutLast) begin
                        instr_q       <= Nop;
                        instr_valid_q <= 1'b1;
                        fault_q       <= 1'b1;
                        cause_q       <= CauseTmo;
                        mem_req_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end else if (tmo_cnt_q != 8'hff) begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_req     = mem_req_q;

endmodule
